// File: rtl/key_debounce.sv
// Multi-channel key debouncer: 2-flop synchroniser, per-channel stability counter, registered press/release pulses.
// Optional auto-repeat of press pulses while held: define KEY_DEBOUNCE_REPEAT_EN. The release pulse port is `rel` (`release` is a reserved word).
module key_debounce #(
   parameter int N         = 8,
   parameter int STABLE    = 10,
   parameter int REP_DELAY = 25,
   parameter int REP_RATE  = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic [N-1:0] raw,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] rel,
   output logic         changed
);
   localparam int CW = $clog2(STABLE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   if (STABLE < 1 || STABLE > 255) begin : g_bad_stable
      $error("key_debounce: STABLE must be in 1..255");
   end
   if (REP_RATE < 1 || REP_DELAY < REP_RATE) begin : g_bad_rep
      $error("key_debounce: need 1 <= REP_RATE <= REP_DELAY");
   end

   logic [N-1:0]         sync_a, sync_b;
   logic [N-1:0][CW-1:0] cnt, cnt_nxt;
   logic [N-1:0]         level_nxt, level_d, accept, rep_hit;
   logic [N-1:0]         rise, fall;

   always_comb begin
      cnt_nxt   = cnt;
      level_nxt = level;
      accept    = '0;
      for (int i = 0; i < N; i++) begin
         if (sync_b[i] == level[i]) begin
            cnt_nxt[i] = '0;
         end else if (tick) begin
            if (cnt[i] == CNT_LAST) begin
               level_nxt[i] = sync_b[i];
               cnt_nxt[i]   = '0;
               accept[i]    = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

`ifdef KEY_DEBOUNCE_REPEAT_EN
   localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY - 1);
   localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_RATE);

   logic [N-1:0][RW-1:0] rcnt, rcnt_nxt;

   // Any acceptance (press or release) restarts the count; a release edge never repeats.
   always_comb begin
      rcnt_nxt = rcnt;
      rep_hit  = '0;
      for (int i = 0; i < N; i++) begin
         if (!level[i] || accept[i]) begin
            rcnt_nxt[i] = '0;
         end else if (tick) begin
            if (rcnt[i] == REP_LAST) begin
               rep_hit[i]  = 1'b1;
               rcnt_nxt[i] = REP_RELOAD;
            end else begin
               rcnt_nxt[i] = rcnt[i] + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt <= '0;
      end else begin
         rcnt <= rcnt_nxt;
      end
   end
`else
   assign rep_hit = '0;
`endif

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a  <= '0;
         sync_b  <= '0;
         cnt     <= '0;
         level   <= '0;
         level_d <= '0;
         press   <= '0;
         rel     <= '0;
         changed <= 1'b0;
      end else begin
         sync_a  <= raw;
         sync_b  <= sync_a;
         cnt     <= cnt_nxt;
         level   <= level_nxt;
         level_d <= level;
         press   <= rise | rep_hit;
         rel     <= fall;
         changed <= |(rise | rep_hit | fall);
      end
   end
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: cycle model of the debounce rules plus directed literal checks.
// The auto-repeat checks are active when KEY_DEBOUNCE_REPEAT_EN is defined.
module tb_key_debounce;
   localparam int N         = 8;
   localparam int STABLE    = 10;
   localparam int REP_DELAY = 25;
   localparam int REP_RATE  = 5;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         tick = 1'b0;
   logic [N-1:0] raw = '0;
   logic [N-1:0] level, press, rel;
   logic         changed;

   logic         tick1 = 1'b1;
   logic [N-1:0] raw1 = '0;
   logic [N-1:0] level1, press1, rel1;
   logic         changed1;

   key_debounce #(.N(N), .STABLE(STABLE), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_dut (
      .clk(clk), .reset(reset), .tick(tick), .raw(raw),
      .level(level), .press(press), .rel(rel), .changed(changed)
   );

   key_debounce #(.N(N), .STABLE(1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_one (
      .clk(clk), .reset(reset), .tick(tick1), .raw(raw1),
      .level(level1), .press(press1), .rel(rel1), .changed(changed1)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int p2_cnt = 0;
   int p3_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: progress is the number of ticks seen while sync has stayed away from level.
   logic [N-1:0] m_s1 = '0, m_s2 = '0, m_sy = '0, m_level = '0;
   logic [N-1:0] m_press = '0, m_rel = '0, m_rose = '0, m_fell = '0;
   logic         m_changed = 1'b0;
   int           m_diff[N];
   int           m_held[N];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = '0; m_s2 = '0; m_level = '0;
         m_press = '0; m_rel = '0; m_rose = '0; m_fell = '0; m_changed = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_diff[i] = 0;
            m_held[i] = 0;
         end
      end else begin
         m_sy    = m_s2;
         m_press = m_rose;
         m_rel   = m_fell;
         m_rose  = '0;
         m_fell  = '0;
         for (int i = 0; i < N; i++) begin
            if (m_sy[i] == m_level[i]) begin
               m_diff[i] = 0;
            end else begin
               if (tick) m_diff[i]++;
               if (m_diff[i] == STABLE) begin
                  m_level[i] = m_sy[i];
                  m_diff[i]  = 0;
                  if (m_sy[i]) begin
                     m_rose[i] = 1'b1;
                     m_held[i] = 0;
                  end else begin
                     m_fell[i] = 1'b1;
                  end
               end
            end
`ifdef KEY_DEBOUNCE_REPEAT_EN
            if (m_level[i] && !m_rose[i] && tick) begin
               m_held[i]++;
               if (m_held[i] >= REP_DELAY && (m_held[i] - REP_DELAY) % REP_RATE == 0)
                  m_press[i] = 1'b1;
            end
`endif
         end
         m_changed = |(m_press | m_rel);
         m_s2 = m_s1;
         m_s1 = raw;
      end
   end

   always @(negedge clk) begin
      check("outputs{level,press,rel,changed}", {level, press, rel, changed},
            {m_level, m_press, m_rel, m_changed});
      if (press[2]) p2_cnt++;
      if (press[3]) p3_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n, input int per);
      repeat (n) begin
         tick = 1'b0;
         step(per - 1);
         tick = 1'b1;
         step(1);
      end
      tick = 1'b0;
   endtask

   initial begin
      // Reset held with all keys pressed and tick high
      raw  = 8'hFF;
      tick = 1'b1;
      step(5);
      check("reset_level", level, 8'h00);
      check("reset_pulses", {press, rel, changed}, 17'h0);

      reset = 1'b1;
      step(11);
      check("post_reset_not_yet", level, 8'h00);
      step(1);
      check("post_reset_accept", level, 8'hFF);
      step(1);
      check("post_reset_press", {press, changed}, {8'hFF, 1'b1});
      step(1);
      check("post_reset_press_gone", press, 8'h00);

      raw = 8'h00;
      ticks(10, 20);
      check("all_released", level, 8'h00);
      step(1);
      check("all_release_pulse", rel, 8'hFF);

      // Clean press on channel 0 with a slow tick
      raw = 8'h01;
      ticks(9, 1000);
      check("clean_press_9", level, 8'h00);
      ticks(1, 1000);
      check("clean_press_10", level, 8'h01);
      step(1);
      check("clean_press_pulse", {press, rel, changed}, {8'h01, 8'h00, 1'b1});
      step(1);
      check("clean_press_one_clk", press, 8'h00);

      // Bouncing channel 3
      p3_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         raw[3] = 1'b1;
         ticks(3, 20);
         raw[3] = 1'b0;
         ticks(3, 20);
      end
      check("bounce_rejected", level, 8'h01);
      raw[3] = 1'b1;
      ticks(9, 20);
      check("bounce_final_9", level, 8'h01);
      ticks(1, 20);
      check("bounce_final_10", level, 8'h09);
      step(2);
      check("bounce_press_count", p3_cnt, 1);

      // Simultaneous release on 1 and press on 6
      raw = 8'h02;
      ticks(10, 20);
      check("simul_setup", level, 8'h02);
      step(2);
      raw = 8'h40;
      ticks(9, 20);
      check("simul_9", level, 8'h02);
      ticks(1, 20);
      check("simul_10", level, 8'h40);
      step(1);
      check("simul_pulses", {press, rel, changed}, {8'h40, 8'h02, 1'b1});

      // STABLE=1 with tick held high
      raw1 = 8'h01;
      step(2);
      check("fast_not_yet", level1, 8'h00);
      step(1);
      check("fast_level", level1, 8'h01);
      step(1);
      check("fast_press", {press1, changed1}, {8'h01, 1'b1});
      step(1);
      check("fast_press_gone", press1, 8'h00);
      raw1 = 8'h00;
      step(3);
      check("fast_fall", level1, 8'h00);
      step(1);
      check("fast_rel", {rel1, press1}, {8'h01, 8'h00});

`ifdef KEY_DEBOUNCE_REPEAT_EN
      raw = 8'h44;
      ticks(10, 20);
      check("rep_accept", level, 8'h44);
      p2_cnt = 0;
      for (int k = 1; k <= 50; k++) begin
         ticks(1, 20);
         check("rep_tick", {24'h0, press[2]}, {24'h0, (k >= REP_DELAY && (k - REP_DELAY) % REP_RATE == 0)});
      end
      check("rep_count", p2_cnt, 7);
      raw = 8'h40;
      ticks(10, 20);
      check("rep_release_level", level, 8'h40);
      check("rep_suppressed", {24'h0, press[2]}, 32'h0);
      step(1);
      check("rep_release_pulse", rel, 8'h04);
      p2_cnt = 0;
      ticks(30, 20);
      check("rep_stopped", p2_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
